// File: rtl/warp_issue_scheduler.sv
// Per-warp instruction buffering with round-robin issue of one eligible warp per cycle.
// Latency: an instruction accepted in cycle N can issue in cycle N+1; up to 1 issue per cycle.
// Backpressure: in_ready drops when the target warp FIFO is full; an offer held by !issue_ready stays locked.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   flush                    synchronous clear of FIFOs, warp states, round-robin pointer
//   warp_enable, sync_release per-warp issue enable / release pulse for warps parked by SYNC
//   in_*                     decoded instruction write side (valid/ready)
//   issue_*                  selected instruction offered to the datapath (valid/ready)
//   warp_waiting             per-warp WAIT state
// Optional: define WIS_PERF_CNT_EN to add perf_issue_cnt / perf_stall_cnt outputs.
module warp_issue_scheduler #(
  parameter int          NUM_WARPS   = 4,
  parameter int          BUF_DEPTH   = 2,
  parameter logic [3:0]  SYNC_OPCODE = 4'hF,
  localparam int         WW          = $clog2(NUM_WARPS),
  localparam int         PW          = $clog2(BUF_DEPTH),
  localparam int         CW          = PW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NUM_WARPS-1:0] warp_enable,
  input  logic [NUM_WARPS-1:0] sync_release,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WW-1:0]        in_warp_id,
  input  logic [3:0]           in_opcode,
  input  logic [3:0]           in_target_reg,
  input  logic [3:0]           in_address_reg,
  input  logic [3:0]           in_imm_short,
  input  logic [1:0]           in_array_id,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [WW-1:0]        issue_warp_id,
  output logic [3:0]           issue_opcode,
  output logic [3:0]           issue_target_reg,
  output logic [3:0]           issue_address_reg,
  output logic [3:0]           issue_imm_short,
  output logic [1:0]           issue_array_id,
`ifdef WIS_PERF_CNT_EN
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_stall_cnt,
`endif
  output logic [NUM_WARPS-1:0] warp_waiting
);

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] target_reg;
    logic [3:0] address_reg;
    logic [3:0] imm_short;
    logic [1:0] array_id;
  } instr_t;

  instr_t               mem    [NUM_WARPS][BUF_DEPTH];
  logic [PW-1:0]        wr_ptr [NUM_WARPS];
  logic [PW-1:0]        rd_ptr [NUM_WARPS];
  logic [CW-1:0]        count  [NUM_WARPS];
  logic [WW-1:0]        rr_ptr;
  logic                 locked;
  logic [WW-1:0]        locked_warp;

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] push_vec;
  logic [NUM_WARPS-1:0] pop_vec;
  logic                 any_eligible;
  logic [WW-1:0]        rr_sel;
  logic [WW-1:0]        sel;
  logic                 push;
  logic                 pop;
  instr_t               in_instr;
  instr_t               head;

  assign in_instr = '{opcode: in_opcode, target_reg: in_target_reg,
                      address_reg: in_address_reg, imm_short: in_imm_short,
                      array_id: in_array_id};

  // Full check uses the registered count only: a same-cycle pop never frees a slot.
  // rst_n gates in_ready so nothing is accepted while reset is held.
  assign in_ready = rst_n && !flush && (count[in_warp_id] != CW'(BUF_DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    any_eligible = 1'b0;
    rr_sel       = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      eligible[w] = (count[w] != '0) && warp_enable[w] && !warp_waiting[w];
    end
    // Rotating search from rr_ptr; index arithmetic wraps because NUM_WARPS is a power of 2.
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (!any_eligible && eligible[rr_ptr + WW'(i)]) begin
        any_eligible = 1'b1;
        rr_sel       = rr_ptr + WW'(i);
      end
    end
  end

  // A stalled offer keeps its warp even if enables change or a higher-priority warp appears.
  assign sel         = locked ? locked_warp : rr_sel;
  assign issue_valid = locked || any_eligible;
  assign pop         = issue_valid && issue_ready;
  assign head        = mem[sel][rd_ptr[sel]];

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      push_vec[w] = push && (in_warp_id == WW'(w));
      pop_vec[w]  = pop && (sel == WW'(w));
    end
  end

  assign issue_warp_id     = issue_valid ? sel : '0;
  assign issue_opcode      = issue_valid ? head.opcode : '0;
  assign issue_target_reg  = issue_valid ? head.target_reg : '0;
  assign issue_address_reg = issue_valid ? head.address_reg : '0;
  assign issue_imm_short   = issue_valid ? head.imm_short : '0;
  assign issue_array_id    = issue_valid ? head.array_id : '0;

  // Storage needs no reset: occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[in_warp_id][wr_ptr[in_warp_id]] <= in_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        wr_ptr[w] <= '0;
        rd_ptr[w] <= '0;
        count[w]  <= '0;
      end
      warp_waiting <= '0;
      rr_ptr       <= '0;
      locked       <= 1'b0;
      locked_warp  <= '0;
`ifdef WIS_PERF_CNT_EN
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
`endif
    end else if (flush) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        wr_ptr[w] <= '0;
        rd_ptr[w] <= '0;
        count[w]  <= '0;
      end
      warp_waiting <= '0;
      rr_ptr       <= '0;
      locked       <= 1'b0;
      locked_warp  <= '0;
`ifdef WIS_PERF_CNT_EN
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
`endif
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (push_vec[w]) wr_ptr[w] <= wr_ptr[w] + PW'(1);
        if (pop_vec[w])  rd_ptr[w] <= rd_ptr[w] + PW'(1);
        count[w] <= count[w] + CW'(push_vec[w]) - CW'(pop_vec[w]);
        // A release coinciding with the SYNC issue cancels the park.
        if (pop_vec[w] && head.opcode == SYNC_OPCODE && !sync_release[w])
          warp_waiting[w] <= 1'b1;
        else if (sync_release[w])
          warp_waiting[w] <= 1'b0;
      end
      if (pop) begin
        rr_ptr <= sel + WW'(1);
        locked <= 1'b0;
      end else if (issue_valid) begin
        locked      <= 1'b1;
        locked_warp <= sel;
      end
`ifdef WIS_PERF_CNT_EN
      if (pop)                         perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (issue_valid && !issue_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed per-cycle vector table plus hand-written reset sequences for warp_issue_scheduler.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Instruction side fields are derived from the opcode so every issued field can be checked.
module tb_warp_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] warp_enable;
  logic [3:0] sync_release;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_warp_id;
  logic [3:0] in_opcode, in_target_reg, in_address_reg, in_imm_short;
  logic [1:0] in_array_id;
  logic       issue_valid;
  logic       issue_ready;
  logic [1:0] issue_warp_id;
  logic [3:0] issue_opcode, issue_target_reg, issue_address_reg, issue_imm_short;
  logic [1:0] issue_array_id;
  logic [3:0] warp_waiting;
`ifdef WIS_PERF_CNT_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  warp_issue_scheduler dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .warp_enable(warp_enable), .sync_release(sync_release),
    .in_valid(in_valid), .in_ready(in_ready), .in_warp_id(in_warp_id),
    .in_opcode(in_opcode), .in_target_reg(in_target_reg),
    .in_address_reg(in_address_reg), .in_imm_short(in_imm_short),
    .in_array_id(in_array_id),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_warp_id(issue_warp_id), .issue_opcode(issue_opcode),
    .issue_target_reg(issue_target_reg), .issue_address_reg(issue_address_reg),
    .issue_imm_short(issue_imm_short), .issue_array_id(issue_array_id),
`ifdef WIS_PERF_CNT_EN
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .warp_waiting(warp_waiting)
  );

  typedef struct {
    logic       fl;
    logic [3:0] en;
    logic [3:0] rel;
    logic       iv;
    logic [1:0] iw;
    logic [3:0] iop;
    logic       ir;
    logic       e_ir;
    logic       e_iv;
    logic [1:0] e_w;
    logic [3:0] e_op;
    logic [3:0] e_wait;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fl, logic [3:0] en, logic [3:0] rel, logic iv,
                              logic [1:0] iw, logic [3:0] iop, logic ir, logic e_ir,
                              logic e_iv, logic [1:0] e_w, logic [3:0] e_op,
                              logic [3:0] e_wait);
    vec_t v;
    v.fl = fl; v.en = en; v.rel = rel; v.iv = iv; v.iw = iw; v.iop = iop; v.ir = ir;
    v.e_ir = e_ir; v.e_iv = e_iv; v.e_w = e_w; v.e_op = e_op; v.e_wait = e_wait;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Side fields are a fixed function of the opcode.
  task automatic drive_in(input logic iv, input logic [1:0] iw, input logic [3:0] op);
    in_valid       = iv;
    in_warp_id     = iw;
    in_opcode      = op;
    in_target_reg  = op ^ 4'h5;
    in_address_reg = ~op;
    in_imm_short   = op + 4'h1;
    in_array_id    = op[1:0];
  endtask

  task automatic chk_fields(input string tag, input logic [1:0] w, input logic [3:0] op);
    logic [3:0] t;
    logic [3:0] a;
    logic [3:0] im;
    t  = op ^ 4'h5;
    a  = ~op;
    im = op + 4'h1;
    chk({tag, " warp"},   32'(issue_warp_id), 32'(w));
    chk({tag, " opcode"}, 32'(issue_opcode), 32'(op));
    chk({tag, " target"}, 32'(issue_target_reg), 32'(t));
    chk({tag, " addr"},   32'(issue_address_reg), 32'(a));
    chk({tag, " imm"},    32'(issue_imm_short), 32'(im));
    chk({tag, " array"},  32'(issue_array_id), 32'(op[1:0]));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " issue_valid"},  32'(issue_valid), 32'd0);
    chk({tag, " warp_waiting"}, 32'(warp_waiting), 32'd0);
    chk({tag, " warp"},   32'(issue_warp_id), 32'd0);
    chk({tag, " opcode"}, 32'(issue_opcode), 32'd0);
    chk({tag, " target"}, 32'(issue_target_reg), 32'd0);
    chk({tag, " addr"},   32'(issue_address_reg), 32'd0);
    chk({tag, " imm"},    32'(issue_imm_short), 32'd0);
    chk({tag, " array"},  32'(issue_array_id), 32'd0);
  endtask

  initial begin
    // fl en rel iv iw op ir | e_ir e_iv e_w e_op e_wait
    // single push to warp 1, issued next cycle
    vecs.push_back(mk(0, 4'hF, 0, 1, 1, 4'h2, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 1, 1, 4'h2, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 0));
    // load warps 3..0 disabled, then enable: round-robin order 0,1,2,3
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 1, 3, 4'h7, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 1, 2, 4'h6, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 1, 1, 4'h5, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 4'h4, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 1, 0, 4'h4, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 1, 1, 4'h5, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 1, 2, 4'h6, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 1, 3, 4'h7, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 0));
    // fill warp 2, third push refused; pop while full does not admit a push
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 1, 2, 4'hA, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 1, 2, 4'hB, 0, 1, 1, 2, 4'hA, 0));
    vecs.push_back(mk(0, 4'hF, 0, 1, 2, 4'hC, 0, 0, 1, 2, 4'hA, 0));
    vecs.push_back(mk(0, 4'hF, 0, 1, 2, 4'hC, 1, 0, 1, 2, 4'hA, 0));
    vecs.push_back(mk(0, 4'hF, 0, 1, 2, 4'hC, 0, 1, 1, 2, 4'hB, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 2, 4'h0, 1, 0, 1, 2, 4'hB, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 2, 4'h0, 1, 1, 1, 2, 4'hC, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 0));
    // SYNC parks warp 0; release to an active warp ignored; release lets 4'h3 go
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 1, 0, 4'hF, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 1, 0, 4'h3, 0, 1, 1, 0, 4'hF, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 0, 1, 0, 4'hF, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 4'h1));
    vecs.push_back(mk(0, 4'hF, 4'h2, 0, 0, 4'h0, 1, 1, 0, 0, 0, 4'h1));
    vecs.push_back(mk(0, 4'hF, 4'h1, 0, 0, 4'h0, 1, 1, 0, 0, 0, 4'h1));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 1, 0, 4'h3, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 0));
    // release in the same cycle as the SYNC issue: warp never waits
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 1, 0, 4'hF, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 4'h1, 1, 0, 4'h3, 1, 1, 1, 0, 4'hF, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 1, 0, 4'h3, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 0));
    // stalled offer of warp 1 stays locked through enable changes
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'h2, 0, 1, 1, 4'h9, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'h2, 0, 1, 0, 4'h8, 0, 1, 1, 1, 4'h9, 0));
    vecs.push_back(mk(0, 4'h3, 0, 0, 0, 4'h0, 0, 1, 1, 1, 4'h9, 0));
    vecs.push_back(mk(0, 4'h1, 0, 0, 0, 4'h0, 0, 1, 1, 1, 4'h9, 0));
    vecs.push_back(mk(0, 4'h3, 0, 0, 0, 4'h0, 1, 1, 1, 1, 4'h9, 0));
    vecs.push_back(mk(0, 4'h3, 0, 0, 0, 4'h0, 1, 1, 1, 0, 4'h8, 0));
    vecs.push_back(mk(0, 4'h3, 0, 0, 0, 4'h0, 1, 1, 0, 0, 0, 0));
    // flush with two warps loaded and a push in the flush cycle
    vecs.push_back(mk(1, 4'hF, 0, 0, 0, 4'h0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 1, 0, 4'h1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 1, 1, 4'h2, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'h0, 0, 1, 2, 4'h3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 2, 4'h0, 1, 1, 0, 0, 0, 0));

    rst_n = 1'b0;
    flush = 1'b0;
    warp_enable = 4'h0;
    sync_release = 4'h0;
    issue_ready = 1'b0;
    drive_in(1'b0, 2'd0, 4'h0);

    #2;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      flush        = vecs[i].fl;
      warp_enable  = vecs[i].en;
      sync_release = vecs[i].rel;
      issue_ready  = vecs[i].ir;
      drive_in(vecs[i].iv, vecs[i].iw, vecs[i].iop);
      @(negedge clk);
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d issue_valid", i), 32'(issue_valid), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d warp_waiting", i), 32'(warp_waiting), 32'(vecs[i].e_wait));
      if (vecs[i].e_iv) chk_fields($sformatf("v%0d", i), vecs[i].e_w, vecs[i].e_op);
    end
`ifdef WIS_PERF_CNT_EN
    chk("perf_issue_cnt after flush", perf_issue_cnt, 32'd0);
    chk("perf_stall_cnt after flush", perf_stall_cnt, 32'd0);
`endif

    // Reset in the middle of a stalled offer: everything clears at once.
    @(posedge clk);
    #1;
    flush = 1'b0;
    warp_enable = 4'hF;
    sync_release = 4'h0;
    issue_ready = 1'b0;
    drive_in(1'b1, 2'd3, 4'hD);
    @(posedge clk);
    #1;
    drive_in(1'b0, 2'd0, 4'h0);
    @(negedge clk);
    chk("pre-reset issue_valid", 32'(issue_valid), 32'd1);
    chk_fields("pre-reset", 2'd3, 4'hD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset in_ready", 32'(in_ready), 32'd0);
    chk_idle_outputs("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue_ready = 1'b1;
    @(negedge clk);
    chk("after reset in_ready", 32'(in_ready), 32'd1);
    chk("after reset issue_valid", 32'(issue_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
- Sits between the instruction decoder and the tensor-core execution array.
- Buffers decoded per-warp instruction fields in small per-warp FIFOs and picks one eligible warp per cycle by round-robin.
- Presents that warp's instruction to the datapath over a valid/ready handshake.
- Implements a SYNC opcode that parks a warp until control releases it.

Parameters:
- NUM_WARPS, 4, number of warps; must be a power of 2, ≥2.
- BUF_DEPTH, 2, entries per warp FIFO; must be a power of 2, ≥2.
- SYNC_OPCODE, 4'hF, opcode that parks the issuing warp in WAIT.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all buffers, warp states and the round-robin pointer.
- warp_enable  input  NUM_WARPS  per-warp issue enable, driven by control.
- sync_release  input  NUM_WARPS  per-warp one-cycle pulse that releases a warp from WAIT.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  instruction accepted when in_valid && in_ready.
- in_warp_id  input  log2(NUM_WARPS)  destination warp FIFO.
- in_opcode  input  4  decoded opcode.
- in_target_reg  input  4  decoded target register.
- in_address_reg  input  4  decoded address register.
- in_imm_short  input  4  decoded short immediate / warp mask.
- in_array_id  input  2  decoded array id.
- issue_valid  output  1  instruction offered to the datapath.
- issue_ready  input  1  datapath accepts the offered instruction.
- issue_warp_id  output  log2(NUM_WARPS)  warp of the offered instruction.
- issue_opcode, issue_target_reg, issue_address_reg, issue_imm_short  output  4 each  fields of the offered instruction.
- issue_array_id  output  2  array id of the offered instruction.
- warp_waiting  output  NUM_WARPS  1 while the warp is in WAIT.

Behaviour:
- Reset (rst_n=0, asynchronous): all FIFOs empty, all warps ACTIVE, rr_ptr=0.
  - issue_valid=0, warp_waiting=0, all issue_* fields=0.
  - in_ready=0 while reset is asserted; in_ready=1 from the first cycle after release.
- Write side:
  - in_ready = !flush && !full[in_warp_id], computed from the current count only.
  - A pop from a full FIFO in the same cycle does NOT free a slot for a same-cycle push.
  - Entries are stored in arrival order per warp.
- Per-warp state, 2 states:
  - ACTIVE -> WAIT when that warp's head with opcode==SYNC_OPCODE completes the issue handshake.
  - WAIT -> ACTIVE on sync_release[w].
  - If sync_release[w] arrives in the same cycle the SYNC issues, the warp stays ACTIVE.
  - sync_release to an ACTIVE warp is ignored.
- Eligibility: warp w is eligible when its FIFO is non-empty, warp_enable[w]=1, and w is ACTIVE.
- Arbitration:
  - Search starts at rr_ptr and wraps modulo NUM_WARPS; the first eligible warp is selected.
  - issue_valid = any eligible. Issue fields are combinational from the selected head.
- Hold rule:
  - While issue_valid && !issue_ready, the selection is locked: same warp, same fields, issue_valid stays 1.
  - This holds even if warp_enable drops or a higher-priority warp becomes eligible.
- Handshake complete (issue_valid && issue_ready):
  - Pop the selected head.
  - rr_ptr <= selected+1, wrapping.
  - The lock clears.
- Latency: an instruction accepted in cycle N is issuable at the earliest in cycle N+1. Throughput is 1 issue/cycle.
- Simultaneous push and pop on the same non-full warp: both happen and the count is unchanged.
- flush has priority over push and pop in the same cycle. Next cycle: all FIFOs empty, all warps ACTIVE, rr_ptr=0, issue_valid=0, lock cleared.
- Reset mid-handshake: everything clears immediately; no partial issue is retained.
- FIFO pointers wrap modulo BUF_DEPTH. The count is log2(BUF_DEPTH)+1 bits wide.

Optional Feature:
- Macro WIS_PERF_CNT_EN.
- When defined, two additional outputs exist:
  - perf_issue_cnt (32-bit): increments on each completed handshake.
  - perf_stall_cnt (32-bit): increments on each cycle with issue_valid && !issue_ready.
  - Both reset to 0 on rst_n and on flush, and wrap on overflow.
- When not defined, neither port nor its logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset then push opcode 4'h2 to warp 1 with issue_ready=1 -> issue_valid=1 the next cycle with issue_warp_id=1 and issue_opcode=4'h2; FIFO empty after the handshake.
- Fill warps 0..3 with one entry each, issue_ready=1 constantly -> issue order 0,1,2,3, then issue_valid=0.
- Push 3 entries to warp 2 (BUF_DEPTH=2) with no issue -> third push sees in_ready=0. Then apply push and issue_ready=1 together while full -> pop occurs, push is refused, count=1.
- Warp 0 head is SYNC (4'hF) followed by 4'h3 -> SYNC issues and warp_waiting[0]=1, 4'h3 is held. Pulse sync_release[0] -> 4'h3 issues the next cycle. A separate run with the release in the same cycle as the SYNC issue -> warp_waiting[0] stays 0.
- Hold issue_ready=0 with warp 1 offered, then enable warp 0 -> warp 1 and its fields stay stable until issue_ready=1.
- Assert flush with 2 warps loaded -> next cycle issue_valid=0, in_ready=1, and all counts are 0. With WIS_PERF_CNT_EN defined, check that the counters show 0 after the flush.
